morty_lsu_wb: RTL and testbench

Registered, parametrised Wishbone B4 classic load/store unit for the Morty core. It replaces the purely combinational lane-select LSU.
- Owns the full bus cycle: address, write-data lane replication, byte selects, read-data extraction with sign/zero extension.
- Detects misaligned accesses and reports bus errors and timeouts.
- Sits between the EX/MEM stage and the data Wishbone bus. It stalls the datapath until the access retires.

---
 rtl/morty_lsu_pkg.sv | 36 +++
 rtl/morty_lsu_align.sv | 84 ++++++++
 rtl/morty_lsu_wb.sv | 141 ++++++++++++++
 tb/tb_morty_lsu_wb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/morty_lsu_pkg.sv
// rtl/morty_lsu_pkg.sv - shared encodings for the Morty Wishbone load/store unit
package morty_lsu_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access size, taken straight from funct3[1:0]
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    function automatic size_t f3_size(input logic [2:0] f3);
        return size_t'(f3[1:0]);
    endfunction

endpackage

// File: rtl/morty_lsu_align.sv
// rtl/morty_lsu_align.sv - byte-lane select, store replication and load extension
module morty_lsu_align
    import morty_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                     funct3,
    input  logic                           we,
    input  logic [$clog2(XLEN/8)-1:0]      offset,
    input  logic [XLEN-1:0]                wdata,
    input  logic [XLEN-1:0]                bus_rdata,
    output logic [XLEN/8-1:0]              sel,
    output logic [XLEN-1:0]                wdata_rep,
    output logic                           misaligned,
    output logic [XLEN-1:0]                rdata_ext
);

    localparam int SEL_W = XLEN / 8;

    size_t           size;
    logic            legal;
    logic            unaligned;
    logic [7:0]      mask;
    logic [XLEN-1:0] shifted;

    assign size       = f3_size(funct3);
    assign misaligned = ~legal | unaligned;
    assign sel        = SEL_W'(mask) << offset;
    assign shifted    = bus_rdata >> {offset, 3'b000};

    // Legal funct3 codes; doubleword and LWU only exist on a 64-bit core
    always_comb begin
        legal = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                F3_SD:               legal = (XLEN == 64);
                default:             legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                F3_LD, F3_LWU:                       legal = (XLEN == 64);
                default:                             legal = 1'b0;
            endcase
        end
    end

    // Natural alignment check and size mask
    always_comb begin
        unaligned = 1'b0;
        mask      = 8'h01;
        case (size)
            SZ_B: mask = 8'h01;
            SZ_H: begin mask = 8'h03; unaligned = offset[0];     end
            SZ_W: begin mask = 8'h0F; unaligned = |offset[1:0]; end
            SZ_D: begin mask = 8'hFF; unaligned = |offset;      end
            default: mask = 8'h01;
        endcase
    end

    // Replicate store data so every lane the slave may pick holds the value
    always_comb begin
        wdata_rep = wdata;
        case (size)
            SZ_B:    wdata_rep = {SEL_W{wdata[7:0]}};
            SZ_H:    wdata_rep = {(SEL_W/2){wdata[15:0]}};
            SZ_W:    wdata_rep = {(XLEN/32){wdata[31:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // Extract the addressed lanes and extend; funct3[2] marks the unsigned loads
    always_comb begin
        rdata_ext = shifted;
        case (size)
            SZ_B: rdata_ext = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            SZ_H: rdata_ext = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            SZ_W: rdata_ext = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/morty_lsu_wb.sv
// rtl/morty_lsu_wb.sv - registered Wishbone B4 classic load/store unit
module morty_lsu_wb
    import morty_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic [XLEN-1:0]     rdata_o,
    output logic                done_o,
    output logic                stall_o,
    output logic                misaligned_o,
    output logic                bus_err_o,
    output logic [XLEN-1:0]     wbm_adr_o,
    output logic [XLEN-1:0]     wbm_dat_o,
    input  logic [XLEN-1:0]     wbm_dat_i,
    output logic                wbm_we_o,
    output logic [XLEN/8-1:0]   wbm_sel_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    localparam int SEL_W = XLEN / 8;
    localparam int OW    = $clog2(SEL_W);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]       state_q;
    logic [2:0]       f3_q;
    logic [OW-1:0]    off_q;
    logic             we_q;
    logic             cyc_q;
    logic             mis_q;
    logic             err_q;
    logic [TW-1:0]    cnt_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  adr_q;
    logic [XLEN-1:0]  dat_q;
    logic [SEL_W-1:0] sel_q;

    logic             idle;
    logic             timeout_hit;
    logic [SEL_W-1:0] a_sel;
    logic [XLEN-1:0]  a_wdata;
    logic [XLEN-1:0]  a_rdata;
    logic             a_mis;

    assign idle        = (state_q == ST_IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1));

    // In IDLE the aligner looks at the live request; during BUS it uses the
    // captured access info so a flush that drops req_i cannot corrupt the load
    morty_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (idle ? funct3_i : f3_q),
        .we         (idle ? we_i : we_q),
        .offset     (idle ? addr_i[OW-1:0] : off_q),
        .wdata      (wdata_i),
        .bus_rdata  (wbm_dat_i),
        .sel        (a_sel),
        .wdata_rep  (a_wdata),
        .misaligned (a_mis),
        .rdata_ext  (a_rdata)
    );

    assign rdata_o      = rdata_q;
    assign done_o       = (state_q == ST_RESP);
    assign misaligned_o = done_o & mis_q;
    assign bus_err_o    = done_o & err_q;
    assign stall_o      = rst_ni & req_i & (state_q != ST_RESP);
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;

    // Access FSM: issue, hold the strobe until ack/err/timeout, then one done cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        f3_q    <= funct3_i;
                        off_q   <= addr_i[OW-1:0];
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        if (a_mis) begin
                            mis_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            mis_q   <= 1'b0;
                            we_q    <= we_i;
                            adr_q   <= {addr_i[XLEN-1:OW], OW'(0)};
                            sel_q   <= a_sel;
                            dat_q   <= a_wdata;
                            cyc_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (wbm_err_i || timeout_hit) begin
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (wbm_ack_i) begin
                        rdata_q <= we_q ? '0 : a_rdata;
                        cyc_q   <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morty_lsu_wb.sv
// tb/tb_morty_lsu_wb.sv - scoreboard bench for the 32- and 64-bit load/store unit
module tb_morty_lsu_wb;

    logic        clk;
    logic        rst_n;
    logic        sel64;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus_rdata;
    logic        ack;
    logic        err;

    logic [31:0] r32, adr32, dat32;
    logic [3:0]  sel32;
    logic        done32, stall32, mis32, berr32, we32, cyc32, stb32;
    logic [63:0] r64, adr64, dat64;
    logic [7:0]  sel64o;
    logic        done64, stall64, mis64, berr64, we64, cyc64, stb64;

    logic [63:0] o_rdata, o_adr, o_dat;
    logic [7:0]  o_sel;
    logic        o_done, o_stall, o_mis, o_berr, o_we, o_cyc, o_stb;

    typedef struct {
        logic [63:0] rd;
        logic        mis;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    morty_lsu_wb #(.XLEN(32), .TIMEOUT(16)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req & ~sel64), .we_i(we), .funct3_i(f3),
        .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .rdata_o(r32), .done_o(done32),
        .stall_o(stall32), .misaligned_o(mis32), .bus_err_o(berr32), .wbm_adr_o(adr32),
        .wbm_dat_o(dat32), .wbm_dat_i(bus_rdata[31:0]), .wbm_we_o(we32), .wbm_sel_o(sel32),
        .wbm_cyc_o(cyc32), .wbm_stb_o(stb32), .wbm_ack_i(ack & ~sel64), .wbm_err_i(err & ~sel64)
    );

    morty_lsu_wb #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req & sel64), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(r64), .done_o(done64),
        .stall_o(stall64), .misaligned_o(mis64), .bus_err_o(berr64), .wbm_adr_o(adr64),
        .wbm_dat_o(dat64), .wbm_dat_i(bus_rdata), .wbm_we_o(we64), .wbm_sel_o(sel64o),
        .wbm_cyc_o(cyc64), .wbm_stb_o(stb64), .wbm_ack_i(ack & sel64), .wbm_err_i(err & sel64)
    );

    assign o_rdata = sel64 ? r64    : {32'b0, r32};
    assign o_adr   = sel64 ? adr64  : {32'b0, adr32};
    assign o_dat   = sel64 ? dat64  : {32'b0, dat32};
    assign o_sel   = sel64 ? sel64o : {4'b0, sel32};
    assign o_done  = sel64 ? done64  : done32;
    assign o_stall = sel64 ? stall64 : stall32;
    assign o_mis   = sel64 ? mis64   : mis32;
    assign o_berr  = sel64 ? berr64  : berr32;
    assign o_we    = sel64 ? we64    : we32;
    assign o_cyc   = sel64 ? cyc64   : cyc32;
    assign o_stb   = sel64 ? stb64   : stb32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", o_rdata, e.rd);
                chk("misaligned", {63'b0, o_mis}, {63'b0, e.mis});
                chk("bus_err", {63'b0, o_berr}, {63'b0, e.err});
            end
        end
    end

    // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave; dly = BUS cycle carrying the response
    task automatic acc(input logic is64, input logic w, input logic [2:0] fn,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input int dly, input int mode, input int exp_cyc,
                       input logic [63:0] exp_rd, input logic exp_mis, input logic exp_err,
                       input logic [7:0] exp_sel, input logic [63:0] exp_adr,
                       input logic [63:0] exp_dat);
        int  ncyc;
        int  done_c;
        bit  got;
        exp_q.push_back('{exp_rd, exp_mis, exp_err});
        sel64 = is64;
        @(posedge clk); #1;
        we = w; f3 = fn; addr = a; wdata = wd; bus_rdata = rd; req = 1'b1;
        #1;
        chk("stall_first_cycle", {63'b0, o_stall}, 64'd1);
        ncyc = 0; done_c = -1; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            ack = 1'b0; err = 1'b0;
            if (o_done) begin
                got = 1; done_c = c;
                chk("stall_in_resp", {63'b0, o_stall}, 64'd0);
            end else if (o_cyc) begin
                ncyc++;
                if (ncyc == 1) begin
                    chk("sel", {56'b0, o_sel}, {56'b0, exp_sel});
                    chk("adr", o_adr, exp_adr);
                    chk("dat_o", o_dat, exp_dat);
                    chk("we_o", {63'b0, o_we}, {63'b0, w});
                    chk("stb", {63'b0, o_stb}, 64'd1);
                end
                if (ncyc == dly) begin
                    ack = (mode == 0 || mode == 2);
                    err = (mode == 1 || mode == 2);
                end
            end
        end
        ack = 1'b0; err = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        chk("cyc_cycles", 64'(ncyc), 64'(exp_cyc));
        chk("done_latency", 64'(done_c), 64'(exp_cyc + 1));
        req = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", {63'b0, o_done}, 64'd0);
        chk("cyc_dropped", {63'b0, o_cyc}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; sel64 = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'd0;
        addr = '0; wdata = '0; bus_rdata = '0; ack = 1'b0; err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cyc", {63'b0, o_cyc}, 64'd0);
        chk("reset_done", {63'b0, o_done}, 64'd0);
        chk("reset_sel_adr", {o_sel, o_adr[55:0]}, 64'd0);
        chk("reset_rdata", o_rdata, 64'd0);

        //   64 w  f3    addr        wdata          bus rdata               dly md cyc exp_rd                 mis err sel    adr         dat
        acc(0, 1, 3'd0, 64'h1003, 64'hA5,         64'h0,                  2, 0, 2,  64'h0,                 0, 0, 8'h08, 64'h1000, 64'hA5A5A5A5);
        acc(0, 0, 3'd1, 64'h2002, 64'h0,          64'h80F01234,           1, 0, 1,  64'hFFFF80F0,          0, 0, 8'h0C, 64'h2000, 64'h0);
        acc(0, 0, 3'd5, 64'h2002, 64'h0,          64'h80F01234,           1, 0, 1,  64'h000080F0,          0, 0, 8'h0C, 64'h2000, 64'h0);
        acc(0, 0, 3'd2, 64'h0006, 64'h0,          64'h0,                  1, 0, 0,  64'h0,                 1, 0, 8'h00, 64'h0,    64'h0);
        acc(0, 0, 3'd2, 64'h3000, 64'h0,          64'h0,                  1, 3, 16, 64'h0,                 0, 1, 8'h0F, 64'h3000, 64'h0);
        acc(0, 1, 3'd2, 64'h0040, 64'h12345678,   64'h0,                  1, 2, 1,  64'h0,                 0, 1, 8'h0F, 64'h0040, 64'h12345678);
        acc(0, 0, 3'd0, 64'h5001, 64'h0,          64'h12348000,           1, 0, 1,  64'hFFFFFF80,          0, 0, 8'h02, 64'h5000, 64'h0);
        acc(0, 0, 3'd4, 64'h5001, 64'h0,          64'h12348000,           1, 0, 1,  64'h00000080,          0, 0, 8'h02, 64'h5000, 64'h0);
        acc(0, 1, 3'd1, 64'h6002, 64'h1234BEEF,   64'h0,                  3, 0, 3,  64'h0,                 0, 0, 8'h0C, 64'h6000, 64'hBEEFBEEF);
        acc(0, 0, 3'd0, 64'h7000, 64'h0,          64'hFF,                 3, 1, 3,  64'h0,                 0, 1, 8'h01, 64'h7000, 64'h0);
        acc(0, 0, 3'd3, 64'h0008, 64'h0,          64'h0,                  1, 0, 0,  64'h0,                 1, 0, 8'h00, 64'h0,    64'h0);
        acc(0, 0, 3'd6, 64'h000C, 64'h0,          64'h0,                  1, 0, 0,  64'h0,                 1, 0, 8'h00, 64'h0,    64'h0);
        acc(0, 1, 3'd4, 64'h0010, 64'h0,          64'h0,                  1, 0, 0,  64'h0,                 1, 0, 8'h00, 64'h0,    64'h0);
        acc(1, 0, 3'd3, 64'h0008, 64'h0,          64'h8000000000000001,   1, 0, 1,  64'h8000000000000001,  0, 0, 8'hFF, 64'h0008, 64'h0);
        acc(1, 0, 3'd6, 64'h000C, 64'h0,          64'hFFFF000012345678,   1, 0, 1,  64'h00000000FFFF0000,  0, 0, 8'hF0, 64'h0008, 64'h0);
        acc(1, 0, 3'd2, 64'h000C, 64'h0,          64'hFFFF000012345678,   2, 0, 2,  64'hFFFFFFFFFFFF0000,  0, 0, 8'hF0, 64'h0008, 64'h0);
        acc(1, 1, 3'd2, 64'h0004, 64'hCAFEBABE,   64'h0,                  1, 0, 1,  64'h0,                 0, 0, 8'hF0, 64'h0000, 64'hCAFEBABECAFEBABE);
        acc(1, 0, 3'd3, 64'h0004, 64'h0,          64'h0,                  1, 0, 0,  64'h0,                 1, 0, 8'h00, 64'h0,    64'h0);

        // Reset in the middle of a bus cycle abandons it with no done pulse
        sel64 = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; f3 = 3'd2; addr = 64'h100; req = 1'b1;
        repeat (3) @(negedge clk);
        chk("midbus_cyc_high", {63'b0, o_cyc}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_cyc", {63'b0, o_cyc}, 64'd0);
        chk("rst_stb", {63'b0, o_stb}, 64'd0);
        chk("rst_stall", {63'b0, o_stall}, 64'd0);
        chk("rst_done", {63'b0, o_done}, 64'd0);
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", {63'b0, o_done}, 64'd0);
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
